// File: rtl/cdctl_pkg.sv
// -----------------------------------------------------------------------------
// cdctl_pkg
//
// Purpose : Shared definitions for the clock-domain reset sequencer and any
//           other block that needs to talk about its states or counter widths.
//
// Contents:
//   CNT_W       - width of the qualification / hold counter
//   LOSS_CNT_W  - width of the saturating lock-loss event counter
//   cdctl_state_e - sequencer states (WAIT, STABLE, RUN, HOLD)
//   loss_cnt_inc  - saturating increment used by the lock-loss counter
// -----------------------------------------------------------------------------
package cdctl_pkg;

  localparam int CNT_W      = 16;
  localparam int LOSS_CNT_W = 8;

  // WAIT   : no synchronized lock seen yet, counter parked at zero
  // STABLE : lock seen, counting consecutive locked cycles
  // RUN    : clock qualified, downstream logic released from reset
  // HOLD   : forced reset extension after lock loss or soft reset
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STABLE = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } cdctl_state_e;

  // Saturating increment: once every bit is set the value sticks, so a long
  // run of lock losses can never wrap back to a small, misleading number.
  function automatic logic [LOSS_CNT_W-1:0] loss_cnt_inc(
    input logic [LOSS_CNT_W-1:0] value
  );
    if (&value) begin
      return value;
    end
    return value + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cdctl_sync2.sv
// -----------------------------------------------------------------------------
// cdctl_sync2
//
// Purpose : Two-flop synchronizer for a single-bit level signal that is
//           asynchronous to clk. Generic so it can be reused for other CDC
//           inputs of the controller.
//
// Ports   :
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears both flops to 0
//   d     - asynchronous input level
//   q     - synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module cdctl_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // The first flop may go metastable; the second gives it a full cycle to
  // resolve before anything downstream looks at the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdctl_rst_seq.sv
// -----------------------------------------------------------------------------
// cdctl_rst_seq
//
// Purpose : Reset sequencer for controller logic clocked by a PLL output.
//           Holds sys_rst until the PLL lock has been seen stable for
//           STABLE_CYCLES consecutive synchronized cycles, then releases it.
//           On lock loss or a soft-reset request the downstream reset is
//           re-asserted and held for at least RST_EXTEND cycles before the
//           qualification sequence starts over.
//
// Parameters:
//   STABLE_CYCLES - consecutive synchronized-lock cycles before release
//                   (legal 2..65535)
//   RST_EXTEND    - minimum sys_rst hold cycles after lock loss / soft reset
//                   (legal 1..65535)
//
// Ports   :
//   clk           - PLL global output clock, the only clock of this block
//   reset         - asynchronous active-high reset
//   pll_lock      - raw PLL LOCK, asynchronous to clk
//   sw_rst        - single-cycle soft-reset request (synchronous to clk)
//   sys_rst       - active-high reset for downstream controller logic
//   ready         - high while the clock is qualified and sys_rst is low
//   lock_loss_cnt - saturating count of lock losses seen while in RUN
//
// Configuration:
//   CDCTL_LOCK_LOSS_CNT_EN - when defined, lock_loss_cnt is implemented;
//                            otherwise the counter is absent and the output
//                            is tied to zero.
// -----------------------------------------------------------------------------
module cdctl_rst_seq
  import cdctl_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_EXTEND    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  sw_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  // Terminal counts, precomputed at the counter width so the comparisons
  // below are plain equality checks.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_EXTEND - 1);

  cdctl_state_e     state;
  cdctl_state_e     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_s;

  // ---------------------------------------------------------------------------
  // Lock synchronizer. Nothing else in this block may look at pll_lock.
  // ---------------------------------------------------------------------------
  cdctl_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // ---------------------------------------------------------------------------
  // State, counter and output registers. sys_rst and ready are decoded from
  // the next state so they change on the same edge as the state itself and
  // come straight out of flops, with no combinational glitching.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT;
      cnt     <= '0;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sys_rst <= (state_next != RUN);
      ready   <= (state_next == RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic.
  //
  // The counter is cleared on every state change so each state that uses it
  // (STABLE, HOLD) starts counting from zero on entry. A soft reset takes
  // priority over lock status everywhere except HOLD, where it is ignored so
  // a stream of requests cannot keep restarting the extension.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;

    case (state)
      WAIT: begin
        cnt_next = '0;
        if (sw_rst) begin
          state_next = HOLD;
        end else if (lock_s) begin
          state_next = STABLE;
        end
      end

      STABLE: begin
        if (sw_rst) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else if (!lock_s) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      RUN: begin
        cnt_next = '0;
        if (!lock_s || sw_rst) begin
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lock-loss event counter.
  //
  // Only a lock drop observed while in RUN counts; a soft reset on its own
  // does not, and a lock drop coinciding with a soft reset counts once.
  // Cleared only by the block reset.
  // ---------------------------------------------------------------------------
`ifdef CDCTL_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if ((state == RUN) && !lock_s) begin
      loss_cnt <= loss_cnt_inc(loss_cnt);
    end
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_cdctl_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_cdctl_rst_seq
//
// Purpose : Self-checking bench for cdctl_rst_seq with short sequencing
//           parameters. A behavioural reference model, phrased as "how many
//           synchronized locked cycles in a row have we seen" and "how many
//           extension cycles remain", predicts sys_rst, ready and the
//           lock-loss count every cycle. Directed sections measure release,
//           lock-loss and soft-reset latencies, asynchronous reset response
//           and counter saturation; a randomized section mixes lock drops and
//           soft resets.
//
// Configuration:
//   CDCTL_LOCK_LOSS_CNT_EN - mirrors the DUT build; when undefined the bench
//                            expects lock_loss_cnt to stay zero.
// -----------------------------------------------------------------------------
module tb_cdctl_rst_seq;

  localparam int SC = 8;
  localparam int RE = 4;

`ifdef CDCTL_LOCK_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       sw_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int compared;
  int mismatched;

  // Reference model state
  bit m_h1;
  bit m_h2;
  bit m_running;
  int m_hold_left;
  int m_streak;
  int m_loss;

  cdctl_rst_seq #(
    .STABLE_CYCLES (SC),
    .RST_EXTEND    (RE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .sw_rst        (sw_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual,
               expected, $time);
    end
  endtask

  task automatic modelReset();
    m_h1        = 1'b0;
    m_h2        = 1'b0;
    m_running   = 1'b0;
    m_hold_left = 0;
    m_streak    = 0;
    m_loss      = 0;
  endtask

  // One clock edge of the reference model. The lock level the sequencer acts
  // on is the raw level from two edges earlier. Release happens once SC+1
  // consecutive locked levels have been seen since the last idle point; a
  // drop or soft reset while running starts a RE-edge extension.
  task automatic modelStep(input bit lock, input bit sw);
    bit ls;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = lock;
    if (m_running) begin
      if (!ls || sw) begin
        m_running   = 1'b0;
        m_hold_left = RE;
        if (!ls && m_loss < 255) m_loss++;
      end
    end else if (m_hold_left > 0) begin
      if (m_hold_left == 1) begin
        m_hold_left = 0;
        m_streak    = 0;
      end else begin
        m_hold_left--;
      end
    end else if (sw) begin
      m_hold_left = RE;
      m_streak    = 0;
    end else if (!ls) begin
      m_streak = 0;
    end else begin
      m_streak++;
      if (m_streak == SC + 1) begin
        m_running = 1'b1;
        m_streak  = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after.
  task automatic applyStimulus(input bit lock, input bit sw);
    pll_lock = lock;
    sw_rst   = sw;
    @(posedge clk);
    modelStep(lock, sw);
    #1;
    checkOutput("sys_rst", 32'(sys_rst), 32'(!m_running));
    checkOutput("ready", 32'(ready), 32'(m_running));
    checkOutput("lock_loss_cnt", 32'(lock_loss_cnt),
                LOSS_EN ? 32'(m_loss) : 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    pll_lock = 1'b0;
    sw_rst   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_sys_rst", 32'(sys_rst), 32'd1);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_loss", 32'(lock_loss_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Hold lock high until ready rises; returns edges taken, bounded.
  task automatic waitReady(input string tag, output int edges);
    edges = 0;
    while (ready !== 1'b1 && edges < 60) begin
      applyStimulus(1'b1, 1'b0);
      edges++;
    end
    if (ready !== 1'b1) checkOutput(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    pll_lock   = 1'b0;
    sw_rst     = 1'b0;
    modelReset();

    // Reset values and release latency from a clean lock rise
    doReset();
    repeat (3) applyStimulus(1'b0, 1'b0);
    waitReady("release_timeout", n);
    checkOutput("release_latency", 32'(n), 32'(SC + 3));

    // Short lock glitch during qualification restarts the count
    doReset();
    repeat (5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitReady("glitch_timeout", n);
    checkOutput("glitch_release_latency", 32'(n), 32'(SC + 3));

    // One-cycle lock drop while running
    n = 0;
    while (sys_rst !== 1'b1 && n < 10) begin
      applyStimulus(n == 0 ? 1'b0 : 1'b1, 1'b0);
      n++;
    end
    checkOutput("lock_loss_latency", 32'(n), 32'd3);
    waitReady("relock_timeout", n);
    checkOutput("relock_edges", 32'(n), 32'(RE + SC + 1));
    checkOutput("loss_after_drop", 32'(lock_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);

    // Soft reset while running with lock held
    applyStimulus(1'b1, 1'b1);
    checkOutput("sw_rst_latency", 32'(sys_rst), 32'd1);
    waitReady("sw_rst_timeout", n);
    checkOutput("sw_rst_rerelease", 32'(n), 32'(RE + SC + 1));
    checkOutput("loss_after_sw_rst", 32'(lock_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);

    // Randomized mix of lock drops and soft resets
    for (int i = 0; i < 3000; i++) begin
      bit lk;
      bit sw;
      lk = ($urandom_range(0, 29) != 0);
      sw = ($urandom_range(0, 49) == 0);
      applyStimulus(lk, sw);
    end

    // Asynchronous reset in the middle of qualification
    doReset();
    repeat (6) applyStimulus(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_stable_sys_rst", 32'(sys_rst), 32'd1);
    checkOutput("async_stable_ready", 32'(ready), 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    waitReady("restart_timeout", n);
    checkOutput("restart_latency", 32'(n), 32'(SC + 3));

    // Asynchronous reset while running: outputs drop before the next edge
    #2 reset = 1'b1;
    #1;
    checkOutput("async_run_sys_rst", 32'(sys_rst), 32'd1);
    checkOutput("async_run_ready", 32'(ready), 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;

    // Lock-loss counter saturation
    doReset();
    for (int i = 0; i < 260; i++) begin
      waitReady("saturate_timeout", n);
      applyStimulus(1'b0, 1'b0);
    end
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("loss_saturate", 32'(lock_loss_cnt), LOSS_EN ? 32'd255 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule

// File: doc/cdctl_rst_seq.md
CDCTL_RST_SEQ -- requirements
Module: cdctl_rst_seq

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before release (legal 2..65535).
REQ-002 SHALL have parameter RST_EXTEND, default 16, meaning minimum sys_rst hold cycles after lock loss or soft reset (legal 1..65535).
REQ-003 SHALL have port clk  input  1  PLL global output clock; sole clock of the block.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pll_lock  input  1  raw PLL LOCK, asynchronous to clk.
REQ-006 SHALL have port sw_rst  input  1  synchronous single-cycle soft-reset request from register block.
REQ-007 SHALL have port sys_rst  output  1  active-high reset for downstream controller logic.
REQ-008 SHALL have port ready  output  1  high while clock is qualified and sys_rst is low.
REQ-009 SHALL have port lock_loss_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-010 SHALL pass pll_lock through a 2-flop synchronizer producing lock_s; no other logic uses pll_lock.
REQ-011 SHALL implement states WAIT, STABLE, RUN, HOLD with a 16-bit down/up counter cnt.
REQ-012 WAIT: cnt=0; lock_s=1 -> STABLE.
REQ-013 STABLE: cnt increments each cycle; lock_s=0 -> WAIT (cnt cleared); lock_s=1 and cnt==STABLE_CYCLES-1 -> RUN.
REQ-014 RUN: lock_s=0 or sw_rst=1 -> HOLD with cnt cleared; otherwise remain.
REQ-015 HOLD: cnt increments regardless of lock_s or sw_rst; cnt==RST_EXTEND-1 -> WAIT.
REQ-016 sw_rst=1 in WAIT or STABLE SHALL force HOLD with cnt cleared; sw_rst in HOLD SHALL be ignored (no restart of extension).
REQ-017 sys_rst and ready SHALL be flops decoded from next state: sys_rst=0, ready=1 exactly in cycles where state==RUN; no glitches.
REQ-018 Release latency SHALL be exactly STABLE_CYCLES+3 clk edges from pll_lock rising (lock held stable, no sw_rst).
REQ-019 Assertion latency on lock loss in RUN SHALL be exactly 3 clk edges from pll_lock falling.
REQ-020 Lock loss in RUN SHALL increment lock_loss_cnt by 1, saturating at 255; sw_rst alone SHALL not increment it; simultaneous lock loss and sw_rst SHALL increment once.
REQ-021 lock_loss_cnt SHALL be cleared only by reset.

Reset
REQ-022 reset SHALL asynchronously force state=WAIT, cnt=0, synchronizer flops=0, sys_rst=1, ready=0, lock_loss_cnt=0.
REQ-023 reset deasserting SHALL take effect on the next clk edge; sys_rst deassertion is always synchronous to clk.
REQ-024 reset asserted mid-STABLE or mid-HOLD SHALL discard progress; sequence restarts from WAIT.

Configuration
REQ-025 Macro CDCTL_LOCK_LOSS_CNT_EN defined: lock_loss_cnt implemented per REQ-020/021.
REQ-026 Macro CDCTL_LOCK_LOSS_CNT_EN undefined: counter flops removed, lock_loss_cnt tied to 8'd0; all other behaviour identical.

Structure
REQ-027 Shared package cdctl_pkg SHALL hold the state enumeration (WAIT, STABLE, RUN, HOLD), CNT_W=16 and LOSS_CNT_W=8 constants.
REQ-028 Synchronizer SHALL be sub-module cdctl_sync2 (2 flops, async active-high reset to 0), reusable for other CDC inputs.

Verification
REQ-029 STABLE_CYCLES=8, pll_lock rises and stays high -> sys_rst falls, ready rises on 11th clk edge after the rise.
REQ-030 STABLE_CYCLES=8, pll_lock high 5 cycles, low 1 cycle, high again -> sys_rst stays 1; release 11 edges after final rise.
REQ-031 RST_EXTEND=4, in RUN pll_lock drops for 1 cycle -> sys_rst=1 at 3rd edge, HOLD 4 cycles, WAIT, re-release after full STABLE count; lock_loss_cnt=1.
REQ-032 In RUN, sw_rst pulse with lock held -> sys_rst=1 next edge, held RST_EXTEND cycles, re-release; lock_loss_cnt unchanged.
REQ-033 256 lock-loss events -> lock_loss_cnt=255, no wrap; with CDCTL_LOCK_LOSS_CNT_EN undefined -> constant 0.
REQ-034 reset asserted mid-STABLE between clk edges -> sys_rst=1, ready=0 immediately (before next edge); full sequence repeats after release.
